// File: rtl/tpu_tile_sequencer_if.sv
// Command and buffer/array control bundle for the 4x4 TPU tile sequencer.
interface tpu_tile_sequencer_if;
  logic        in_valid;
  logic [7:0]  K;
  logic [7:0]  M;
  logic [7:0]  N;
  logic        busy;
  logic        A_wr_en;
  logic        B_wr_en;
  logic [15:0] A_index;
  logic [15:0] B_index;
  logic        C_wr_en;
  logic [15:0] C_index;
  logic        arr_clear;
  logic        arr_feed;
  logic [1:0]  acc_row_sel;

  modport master (
    input  in_valid, K, M, N,
    output busy, A_wr_en, B_wr_en, A_index, B_index,
           C_wr_en, C_index, arr_clear, arr_feed, acc_row_sel
  );

  modport slave (
    output in_valid, K, M, N,
    input  busy, A_wr_en, B_wr_en, A_index, B_index,
           C_wr_en, C_index, arr_clear, arr_feed, acc_row_sel
  );
endinterface

// File: rtl/tpu_tile_sequencer.sv
// Walks an MxN matmul output in 4x4 tiles: feeds A/B reads, waits out the
// array drain, then writes C rows. All outputs are registered.
module tpu_tile_sequencer #(
  parameter int unsigned DRAIN = 7
) (
  input logic                   clk,
  input logic                   rst_n,
  tpu_tile_sequencer_if.master  bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_FEED, ST_DRAIN, ST_WRITE} state_e;

  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN - 1);

  state_e      state_q, state_d;
  logic [7:0]  k_q, k_d, m_q, m_d, n_q, n_d;
  logic        zero_q, zero_d;
  logic [6:0]  tr_q, tr_d, tc_q, tc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;

  logic        busy_q, busy_d;
  logic [15:0] a_idx_q, a_idx_d, b_idx_q, b_idx_d, c_idx_q, c_idx_d;
  logic        clear_q, clear_d, cwr_q, cwr_d, feed_q;
  logic [1:0]  row_q, row_d;

  logic [8:0]  tm9, tn9, rem9;
  logic [2:0]  rows;
  logic        tc_last, tr_last, row_last, feed_nx;

  always_comb begin
    tm9      = ({1'b0, m_q} + 9'd3) >> 2;
    tn9      = ({1'b0, n_q} + 9'd3) >> 2;
    rem9     = {1'b0, m_q} - {tr_q, 2'b00};
    rows     = (rem9 >= 9'd4) ? 3'd4 : rem9[2:0];
    tc_last  = ({2'b00, tc_q} == tn9 - 9'd1);
    tr_last  = ({2'b00, tr_q} == tm9 - 9'd1);
    row_last = (cnt_q == {5'b00000, rows} - 8'd1);
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    m_d      = m_q;
    n_d      = n_q;
    zero_d   = zero_q;
    tr_d     = tr_q;
    tc_d     = tc_q;
    cnt_d    = cnt_q;
    a_base_d = a_base_q;
    b_base_d = b_base_q;
    c_base_d = c_base_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          k_d      = bus.K;
          m_d      = bus.M;
          n_d      = bus.N;
          zero_d   = (bus.K == 8'd0) || (bus.M == 8'd0) || (bus.N == 8'd0);
          tr_d     = '0;
          tc_d     = '0;
          cnt_d    = '0;
          a_base_d = '0;
          b_base_d = '0;
          c_base_d = '0;
          state_d  = zero_d ? ST_WRITE : ST_FEED;
        end
      end
      ST_FEED: begin
        if (cnt_q == k_q - 8'd1) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = '0;
          state_d = ST_WRITE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_WRITE: begin
        // A zero-sized command parks here for one cycle with no rows to write.
        if (zero_q) begin
          state_d = ST_IDLE;
        end else if (row_last) begin
          cnt_d = '0;
          if (!tc_last) begin
            tc_d     = tc_q + 7'd1;
            b_base_d = b_base_q + {8'h00, k_q};
            c_base_d = c_base_q + {8'h00, m_q};
            state_d  = ST_FEED;
          end else if (!tr_last) begin
            tr_d     = tr_q + 7'd1;
            tc_d     = '0;
            a_base_d = a_base_q + {8'h00, k_q};
            b_base_d = '0;
            c_base_d = {7'b0000000, tr_d, 2'b00};
            state_d  = ST_FEED;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are computed from next state so they are registered yet aligned.
    feed_nx = (state_d == ST_FEED);
    cwr_d   = (state_d == ST_WRITE) && !zero_d;
    busy_d  = (state_d != ST_IDLE);
    a_idx_d = feed_nx ? a_base_d + {8'h00, cnt_d} : '0;
    b_idx_d = feed_nx ? b_base_d + {8'h00, cnt_d} : '0;
    clear_d = feed_nx && (cnt_d == 8'd0);
    c_idx_d = cwr_d ? c_base_d + {8'h00, cnt_d} : '0;
    row_d   = cwr_d ? cnt_d[1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      m_q      <= '0;
      n_q      <= '0;
      zero_q   <= 1'b0;
      tr_q     <= '0;
      tc_q     <= '0;
      cnt_q    <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      busy_q   <= 1'b0;
      a_idx_q  <= '0;
      b_idx_q  <= '0;
      c_idx_q  <= '0;
      clear_q  <= 1'b0;
      cwr_q    <= 1'b0;
      feed_q   <= 1'b0;
      row_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      m_q      <= m_d;
      n_q      <= n_d;
      zero_q   <= zero_d;
      tr_q     <= tr_d;
      tc_q     <= tc_d;
      cnt_q    <= cnt_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      busy_q   <= busy_d;
      a_idx_q  <= a_idx_d;
      b_idx_q  <= b_idx_d;
      c_idx_q  <= c_idx_d;
      clear_q  <= clear_d;
      cwr_q    <= cwr_d;
      feed_q   <= (state_q == ST_FEED);
      row_q    <= row_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.A_wr_en     = 1'b0;
  assign bus.B_wr_en     = 1'b0;
  assign bus.A_index     = a_idx_q;
  assign bus.B_index     = b_idx_q;
  assign bus.C_wr_en     = cwr_q;
  assign bus.C_index     = c_idx_q;
  assign bus.arr_clear   = clear_q;
  assign bus.arr_feed    = feed_q;
  assign bus.acc_row_sel = row_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Scoreboard bench for tpu_tile_sequencer: expected feed addresses, C writes
// and busy lengths are queued per command and consumed as the DUT emits them.
module tb_tpu_tile_sequencer;

  localparam int unsigned DRAIN_C = 7;

  logic clk;
  logic rst_n;

  tpu_tile_sequencer_if bus ();

  tpu_tile_sequencer #(.DRAIN(DRAIN_C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int unsigned a; int unsigned b; bit clr; } feed_t;
  typedef struct { int unsigned idx; int unsigned row; } cwr_t;

  feed_t       fq[$];
  cwr_t        cq[$];
  int unsigned bq[$];

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned c_writes = 0;
  int unsigned run      = 0;

  logic [15:0] prev_a, prev_b;
  logic        prev_clr;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_model(input int unsigned k, input int unsigned m, input int unsigned n);
    int unsigned tm, tn, r, total;
    if (k == 0 || m == 0 || n == 0) begin
      bq.push_back(1);
    end else begin
      tm = (m + 3) / 4;
      tn = (n + 3) / 4;
      total = 0;
      for (int unsigned tr = 0; tr < tm; tr++) begin
        for (int unsigned tc = 0; tc < tn; tc++) begin
          for (int unsigned kk = 0; kk < k; kk++)
            fq.push_back('{a: tr * k + kk, b: tc * k + kk, clr: (kk == 0)});
          r = (m - 4 * tr > 4) ? 4 : m - 4 * tr;
          for (int unsigned rr = 0; rr < r; rr++)
            cq.push_back('{idx: tc * m + 4 * tr + rr, row: rr});
          total += k + DRAIN_C + r;
        end
      end
      bq.push_back(total);
    end
  endtask

  // Caller is positioned at a negedge; returns at posedge+1 with in_valid low.
  task automatic cmd(input int unsigned k, input int unsigned m, input int unsigned n);
    bus.in_valid = 1'b1;
    bus.K = 8'(k);
    bus.M = 8'(m);
    bus.N = 8'(n);
    push_model(k, m, n);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("busy_rise", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_idle(input int unsigned limit);
    bit done;
    done = 1'b0;
    for (int unsigned i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (!bus.busy) done = 1'b1;
    end
    check_eq("idle_timeout", 64'(done), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
    end else begin
      check_eq("ab_wr_en", {62'd0, bus.A_wr_en, bus.B_wr_en}, 64'd0);
      if (bus.arr_feed) begin
        check_eq("feed_expected", 64'(fq.size() != 0), 64'd1);
        if (fq.size() != 0) begin
          feed_t e;
          e = fq.pop_front();
          check_eq("A_index", 64'(prev_a), 64'(e.a));
          check_eq("B_index", 64'(prev_b), 64'(e.b));
          check_eq("arr_clear", 64'(prev_clr), 64'(e.clr));
        end
      end
      if (bus.C_wr_en) begin
        c_writes++;
        check_eq("cwr_expected", 64'(cq.size() != 0), 64'd1);
        if (cq.size() != 0) begin
          cwr_t e;
          e = cq.pop_front();
          check_eq("C_index", 64'(bus.C_index), 64'(e.idx));
          check_eq("acc_row_sel", 64'(bus.acc_row_sel), 64'(e.row));
        end
      end else begin
        check_eq("c_quiet", {46'd0, bus.C_index, bus.acc_row_sel}, 64'd0);
      end
      if (bus.busy) begin
        run++;
      end else begin
        if (run > 0) begin
          check_eq("busy_expected", 64'(bq.size() != 0), 64'd1);
          if (bq.size() != 0) check_eq("busy_len", 64'(run), 64'(bq.pop_front()));
          run = 0;
        end
        check_eq("idle_out", {30'd0, bus.A_index, bus.B_index, bus.arr_clear, bus.arr_feed}, 64'd0);
      end
    end
    prev_a   = bus.A_index;
    prev_b   = bus.B_index;
    prev_clr = bus.arr_clear;
  end

  initial begin
    int unsigned cw0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.K        = '0;
    bus.M        = '0;
    bus.N        = '0;
    #23;
    check_eq("rst_ctrl", {58'd0, bus.busy, bus.A_wr_en, bus.B_wr_en, bus.C_wr_en,
                          bus.arr_clear, bus.arr_feed}, 64'd0);
    check_eq("rst_idx", {14'd0, bus.A_index, bus.B_index, bus.C_index, bus.acc_row_sel}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    cmd(4, 4, 4);
    wait_idle(200);
    @(negedge clk);

    cmd(2, 8, 8);
    wait_idle(200);
    @(negedge clk);

    cw0 = c_writes;
    cmd(3, 6, 5);
    wait_idle(200);
    check_eq("c_writes_365", 64'(c_writes - cw0), 64'd12);
    @(negedge clk);

    cw0 = c_writes;
    cmd(0, 4, 4);
    wait_idle(20);
    @(negedge clk);
    cmd(4, 0, 4);
    wait_idle(20);
    check_eq("zero_no_write", 64'(c_writes - cw0), 64'd0);
    @(negedge clk);

    // Stray command mid-flight must be ignored; next one lands in the busy-fall cycle.
    cmd(2, 4, 8);
    repeat (4) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.K = 8'd5;
    bus.M = 8'd5;
    bus.N = 8'd5;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_idle(200);
    cmd(1, 4, 4);
    wait_idle(200);
    @(negedge clk);

    cmd(2, 8, 8);
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    fq.delete();
    cq.delete();
    bq.delete();
    #1;
    check_eq("arst_ctrl", {58'd0, bus.busy, bus.A_wr_en, bus.B_wr_en, bus.C_wr_en,
                           bus.arr_clear, bus.arr_feed}, 64'd0);
    check_eq("arst_idx", {14'd0, bus.A_index, bus.B_index, bus.C_index, bus.acc_row_sel}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("post_rst_idle", 64'(bus.busy), 64'd0);
    cmd(1, 4, 4);
    wait_idle(200);
    repeat (2) @(negedge clk);

    check_eq("fq_drained", 64'(fq.size()), 64'd0);
    check_eq("cq_drained", 64'(cq.size()), 64'd0);
    check_eq("bq_drained", 64'(bq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
